// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and helpers used by the decoder/mux stage.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HrespOkay  = 2'b00,
    HrespError = 2'b01
  } hresp_e;

  // The default subordinate is encoded one past the last decoded subordinate.
  function automatic int unsigned def_sel_idx(input int unsigned num_subs);
    return num_subs;
  endfunction

endpackage

// File: rtl/ahb_lite_addr_decoder.sv
// Combinational region decode: upper address bits pick one subordinate or the default.
module ahb_lite_addr_decoder
  import ahb_lite_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned RegionBits = 4,
  parameter int unsigned NumSubs    = 4,
  parameter int unsigned SelW       = 3
) (
  input  logic [AddrWidth-1:0] haddr_i,
  output logic [NumSubs-1:0]   hsel_s_o,
  output logic                 hsel_def_o,
  output logic [SelW-1:0]      sel_idx_o
);

  logic [RegionBits-1:0] region;
  assign region = haddr_i[AddrWidth-1 -: RegionBits];

  // Only the region bits take part in decoding.
  logic unused_addr;
  assign unused_addr = ^haddr_i[AddrWidth-RegionBits-1:0];

  // One-hot select; falls through to the default when no region matches.
  always_comb begin
    hsel_s_o   = '0;
    hsel_def_o = 1'b1;
    sel_idx_o  = SelW'(def_sel_idx(NumSubs));
    for (int unsigned i = 0; i < NumSubs; i++) begin
      if (region == RegionBits'(i)) begin
        hsel_s_o[i] = 1'b1;
        hsel_def_o  = 1'b0;
        sel_idx_o   = SelW'(i);
      end
    end
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer for a single manager.
// Optional statistics counters are enabled with AHB_DECODER_MUX_STATS_EN.
module ahb_decoder_mux
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_SUBS    = 4,
  parameter int unsigned REGION_BITS = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_WIDTH-1:0]        HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SUBS-1:0]          HSEL_S,
  output logic                         HSEL_DEF,
  input  logic [NUM_SUBS*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [2*NUM_SUBS-1:0]        HRESP_S,
  input  logic [NUM_SUBS-1:0]          HREADYOUT_S,
  input  logic [DATA_WIDTH-1:0]        HRDATA_DEF,
  input  logic [1:0]                   HRESP_DEF,
  input  logic                         HREADYOUT_DEF,
  output logic [DATA_WIDTH-1:0]        HRDATA,
  output logic [1:0]                   HRESP,
  output logic                         HREADY
`ifdef AHB_DECODER_MUX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]         XFER_CNT,
  output logic [CNT_WIDTH-1:0]         DECERR_CNT
`endif
);

  localparam int unsigned SelW = $clog2(NUM_SUBS + 1);
  localparam logic [SelW-1:0] DefIdx = SelW'(def_sel_idx(NUM_SUBS));

  if (NUM_SUBS < 1 || NUM_SUBS > (1 << REGION_BITS)) begin : g_cfg_err
    $error("ahb_decoder_mux: NUM_SUBS must be in 1..2**REGION_BITS");
  end

  logic [SelW-1:0] sel_idx;

  ahb_lite_addr_decoder #(
    .AddrWidth (ADDR_WIDTH),
    .RegionBits(REGION_BITS),
    .NumSubs   (NUM_SUBS),
    .SelW      (SelW)
  ) u_addr_decoder (
    .haddr_i   (HADDR),
    .hsel_s_o  (HSEL_S),
    .hsel_def_o(HSEL_DEF),
    .sel_idx_o (sel_idx)
  );

  // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  logic [SelW-1:0] dsel_q, dsel_d;
  logic            dvalid_q, dvalid_d;

  // Address phase is captured into the data phase only when the bus is ready.
  always_comb begin
    dsel_d   = dsel_q;
    dvalid_d = dvalid_q;
    if (HREADY) begin
      dsel_d   = sel_idx;
      dvalid_d = HTRANS[1];
    end
  end

  // Data-phase register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q   <= DefIdx;
      dvalid_q <= 1'b0;
    end else begin
      dsel_q   <= dsel_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Response mux; with no active data phase the stage answers OKAY/ready itself.
  always_comb begin
    HRDATA = '0;
    HRESP  = HrespOkay;
    HREADY = 1'b1;
    if (dvalid_q) begin
      HRDATA = HRDATA_DEF;
      HRESP  = HRESP_DEF;
      HREADY = HREADYOUT_DEF;
      for (int unsigned i = 0; i < NUM_SUBS; i++) begin
        if (dsel_q == SelW'(i)) begin
          HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
          HRESP  = HRESP_S[2*i +: 2];
          HREADY = HREADYOUT_S[i];
        end
      end
    end
  end

`ifdef AHB_DECODER_MUX_STATS_EN
  logic                 xfer_done;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_WIDTH-1:0] decerr_cnt_q, decerr_cnt_d;

  assign xfer_done = dvalid_q & HREADY;

  // Saturating completion counters.
  always_comb begin
    xfer_cnt_d   = xfer_cnt_q;
    decerr_cnt_d = decerr_cnt_q;
    if (xfer_done && (xfer_cnt_q != '1)) begin
      xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
    end
    if (xfer_done && (dsel_q == DefIdx) && (decerr_cnt_q != '1)) begin
      decerr_cnt_d = decerr_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      xfer_cnt_q   <= '0;
      decerr_cnt_q <= '0;
    end else begin
      xfer_cnt_q   <= xfer_cnt_d;
      decerr_cnt_q <= decerr_cnt_d;
    end
  end

  assign XFER_CNT   = xfer_cnt_q;
  assign DECERR_CNT = decerr_cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule
